// File: rtl/sram_req_arbiter.sv
// Arbitrates the IF and MEM SRAM-like requesters onto one downstream port, remembers the order
// of accepted requests and steers each in-order response back to its originator.
module sram_req_arbiter #(
  parameter int unsigned MAX_OUTST  = 4,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic        clk,
  input  logic        resetn,
  // IF requester
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // MEM requester
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  // Downstream port
  output logic        m_sram_req,
  output logic        m_sram_wr,
  output logic [1:0]  m_sram_size,
  output logic [3:0]  m_sram_wstrb,
  output logic [31:0] m_sram_addr,
  output logic [31:0] m_sram_wdata,
  input  logic        m_sram_addr_ok,
  input  logic        m_sram_data_ok,
  input  logic [31:0] m_sram_rdata,
  // Status
  output logic [2:0]  outst_cnt,
  output logic        resp_err
);

  localparam int unsigned PtrW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned StW  = $clog2(STARVE_LIM + 1);
  localparam logic [2:0]      CntMax  = 3'(MAX_OUTST);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MAX_OUTST - 1);
  localparam logic [StW-1:0]  StLim   = StW'(STARVE_LIM);

  // Order FIFO: one source bit per outstanding request (0 = inst, 1 = data)
  logic [MAX_OUTST-1:0] src_q, src_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [StW-1:0]       starve_q, starve_d;
  logic                 err_q, err_d;

  logic full, empty, starved;
  logic grant_inst, grant_data;
  logic push, pop, head_src;

  assign full    = (cnt_q == CntMax);
  assign empty   = (cnt_q == 3'd0);
  assign starved = (starve_q == StLim);

  // Grant selection; the full FIFO blocks every grant. Reset gates outputs to 0.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (resetn && !full) begin
      if (starved && inst_sram_req) begin
        grant_inst = 1'b1;
      end else if (data_sram_req) begin
        grant_data = 1'b1;
      end else if (inst_sram_req) begin
        grant_inst = 1'b1;
      end
    end
  end

  // Downstream request mux from the granted requester, zero when idle
  always_comb begin
    m_sram_req   = 1'b0;
    m_sram_wr    = 1'b0;
    m_sram_size  = 2'd0;
    m_sram_wstrb = 4'd0;
    m_sram_addr  = 32'd0;
    m_sram_wdata = 32'd0;
    if (grant_inst) begin
      m_sram_req   = inst_sram_req;
      m_sram_wr    = inst_sram_wr;
      m_sram_size  = inst_sram_size;
      m_sram_wstrb = inst_sram_wstrb;
      m_sram_addr  = inst_sram_addr;
      m_sram_wdata = inst_sram_wdata;
    end else if (grant_data) begin
      m_sram_req   = data_sram_req;
      m_sram_wr    = data_sram_wr;
      m_sram_size  = data_sram_size;
      m_sram_wstrb = data_sram_wstrb;
      m_sram_addr  = data_sram_addr;
      m_sram_wdata = data_sram_wdata;
    end
  end

  assign push     = m_sram_req & m_sram_addr_ok;
  assign pop      = resetn & m_sram_data_ok & ~empty;
  assign head_src = src_q[rd_ptr_q];

  assign inst_sram_addr_ok = m_sram_addr_ok & grant_inst;
  assign data_sram_addr_ok = m_sram_addr_ok & grant_data;
  assign inst_sram_data_ok = pop & ~head_src;
  assign data_sram_data_ok = pop & head_src;
  assign inst_sram_rdata   = resetn ? m_sram_rdata : 32'd0;
  assign data_sram_rdata   = resetn ? m_sram_rdata : 32'd0;

  assign outst_cnt = cnt_q;
  assign resp_err  = err_q;

  // Next-state for order FIFO, starve counter and sticky error
  always_comb begin
    src_d    = src_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    err_d    = err_q;

    if (push) begin
      src_d[wr_ptr_q] = grant_data;
      wr_ptr_d        = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase

    if (inst_sram_req && !inst_sram_addr_ok) begin
      starve_d = starved ? starve_q : starve_q + 1'b1;
    end else begin
      starve_d = '0;
    end

    // A response with nothing outstanding indicates a protocol fault downstream
    if (m_sram_data_ok && empty) begin
      err_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      src_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= 3'd0;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      src_q    <= src_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: arbitration, starvation override, order tracking,
// full-FIFO back-pressure, pointer wrap, orphan responses and asynchronous reset.
module tb_sram_req_arbiter;

  localparam logic [31:0] IA = 32'h1c00_0000;
  localparam logic [31:0] DA = 32'h8000_1000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        m_sram_req, m_sram_wr;
  logic [1:0]  m_sram_size;
  logic [3:0]  m_sram_wstrb;
  logic [31:0] m_sram_addr, m_sram_wdata;
  logic        m_sram_addr_ok, m_sram_data_ok;
  logic [31:0] m_sram_rdata;
  logic [2:0]  outst_cnt;
  logic        resp_err;

  int total = 0;
  int bad   = 0;
  logic exp_q[$];
  logic head;

  always #5 clk = ~clk;

  sram_req_arbiter #(.MAX_OUTST(4), .STARVE_LIM(8)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .m_sram_req(m_sram_req), .m_sram_wr(m_sram_wr), .m_sram_size(m_sram_size),
    .m_sram_wstrb(m_sram_wstrb), .m_sram_addr(m_sram_addr), .m_sram_wdata(m_sram_wdata),
    .m_sram_addr_ok(m_sram_addr_ok), .m_sram_data_ok(m_sram_data_ok),
    .m_sram_rdata(m_sram_rdata),
    .outst_cnt(outst_cnt), .resp_err(resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Settle combinational outputs before sampling
  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_wstrb = 4'h0;
    inst_sram_addr = IA; inst_sram_wdata = 32'h0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_wstrb = 4'h0;
    data_sram_addr = DA; data_sram_wdata = 32'h0;
    m_sram_addr_ok = 0; m_sram_data_ok = 0; m_sram_rdata = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 0;
    tick(); tick();
    resetn = 1;
    tick();
  endtask

  initial begin
    idle_inputs();
    resetn = 0;
    #3;
    chk("rst_cnt", 32'(outst_cnt), 0);
    chk("rst_err", 32'(resp_err), 0);
    chk("rst_mreq", 32'(m_sram_req), 0);
    tick();
    resetn = 1;
    tick();

    // 1: single inst read, response two cycles after accept
    inst_sram_req = 1; m_sram_addr_ok = 1;
    settle();
    chk("t1_iaok", 32'(inst_sram_addr_ok), 1);
    chk("t1_daok", 32'(data_sram_addr_ok), 0);
    chk("t1_mreq", 32'(m_sram_req), 1);
    chk("t1_maddr", m_sram_addr, IA);
    chk("t1_cnt0", 32'(outst_cnt), 0);
    tick();
    inst_sram_req = 0; m_sram_addr_ok = 0;
    chk("t1_cnt1", 32'(outst_cnt), 1);
    tick();
    m_sram_data_ok = 1; m_sram_rdata = 32'h0280_0000;
    settle();
    chk("t1_idok", 32'(inst_sram_data_ok), 1);
    chk("t1_ddok", 32'(data_sram_data_ok), 0);
    chk("t1_rdata", inst_sram_rdata, 32'h0280_0000);
    tick();
    m_sram_data_ok = 0;
    chk("t1_cnt2", 32'(outst_cnt), 0);
    chk("t1_err", 32'(resp_err), 0);

    // 2: both requesting, always ready: 8 data wins then one forced inst win
    do_reset();
    inst_sram_req = 1; data_sram_req = 1; m_sram_addr_ok = 1;
    for (int i = 0; i < 27; i++) begin
      m_sram_data_ok = (i > 0);
      settle();
      chk($sformatf("t2_iaok_%0d", i), 32'(inst_sram_addr_ok), 32'((i % 9) == 8));
      chk($sformatf("t2_daok_%0d", i), 32'(data_sram_addr_ok), 32'((i % 9) != 8));
      chk($sformatf("t2_maddr_%0d", i), m_sram_addr, ((i % 9) == 8) ? IA : DA);
      tick();
    end
    chk("t2_cnt", 32'(outst_cnt), 1);

    // 3: fill FIFO with 4 inst reads, then back-pressure and release
    do_reset();
    inst_sram_req = 1; m_sram_addr_ok = 1;
    repeat (4) tick();
    chk("t3_cnt4", 32'(outst_cnt), 4);
    data_sram_req = 1;
    settle();
    chk("t3_mreq_full", 32'(m_sram_req), 0);
    chk("t3_iaok_full", 32'(inst_sram_addr_ok), 0);
    chk("t3_daok_full", 32'(data_sram_addr_ok), 0);
    chk("t3_maddr_full", m_sram_addr, 0);
    m_sram_data_ok = 1;
    settle();
    chk("t3_idok", 32'(inst_sram_data_ok), 1);
    tick();
    m_sram_data_ok = 0; m_sram_addr_ok = 0;
    settle();
    chk("t3_cnt3", 32'(outst_cnt), 3);
    chk("t3_mreq_rel", 32'(m_sram_req), 1);
    chk("t3_maddr_rel", m_sram_addr, DA);

    // 4: order data, inst, data; responses routed back in that order
    do_reset();
    data_sram_req = 1; data_sram_wr = 1; data_sram_wstrb = 4'hf; data_sram_wdata = 32'h5555_aaaa;
    inst_sram_req = 1; m_sram_addr_ok = 1;
    settle();
    chk("t4_mwr", 32'(m_sram_wr), 1);
    chk("t4_mwstrb", 32'(m_sram_wstrb), 32'hf);
    chk("t4_mwdata", m_sram_wdata, 32'h5555_aaaa);
    tick();
    data_sram_req = 0;
    settle();
    chk("t4_iaok", 32'(inst_sram_addr_ok), 1);
    chk("t4_mwr_inst", 32'(m_sram_wr), 0);
    tick();
    inst_sram_req = 0; data_sram_req = 1;
    tick();
    data_sram_req = 0; m_sram_addr_ok = 0;
    chk("t4_cnt3", 32'(outst_cnt), 3);
    m_sram_data_ok = 1; m_sram_rdata = 32'hA;
    settle();
    chk("t4_r0_d", 32'(data_sram_data_ok), 1);
    chk("t4_r0_i", 32'(inst_sram_data_ok), 0);
    chk("t4_r0_rd", data_sram_rdata, 32'hA);
    tick();
    m_sram_rdata = 32'hB;
    settle();
    chk("t4_r1_d", 32'(data_sram_data_ok), 0);
    chk("t4_r1_i", 32'(inst_sram_data_ok), 1);
    chk("t4_r1_rd", inst_sram_rdata, 32'hB);
    tick();
    m_sram_rdata = 32'hC;
    settle();
    chk("t4_r2_d", 32'(data_sram_data_ok), 1);
    chk("t4_r2_i", 32'(inst_sram_data_ok), 0);
    chk("t4_r2_rd", data_sram_rdata, 32'hC);
    tick();
    m_sram_data_ok = 0;
    chk("t4_cnt0", 32'(outst_cnt), 0);
    chk("t4_err", 32'(resp_err), 0);

    // 5: cnt=2, then push+pop every cycle across pointer wrap
    do_reset();
    exp_q.delete();
    inst_sram_req = 1; m_sram_addr_ok = 1;
    tick(); exp_q.push_back(1'b0);
    tick(); exp_q.push_back(1'b0);
    chk("t5_cnt2", 32'(outst_cnt), 2);
    for (int i = 0; i < 11; i++) begin
      inst_sram_req = ((i % 2) == 0);
      data_sram_req = ((i % 2) == 1);
      m_sram_data_ok = 1;
      m_sram_rdata = 32'(i);
      head = exp_q[0];
      settle();
      chk($sformatf("t5_idok_%0d", i), 32'(inst_sram_data_ok), 32'(head == 1'b0));
      chk($sformatf("t5_ddok_%0d", i), 32'(data_sram_data_ok), 32'(head == 1'b1));
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back((i % 2) == 1);
      chk($sformatf("t5_cnt_%0d", i), 32'(outst_cnt), 2);
    end

    // 6: orphan response, then async reset mid-transaction
    do_reset();
    m_sram_data_ok = 1;
    settle();
    chk("t6_idok", 32'(inst_sram_data_ok), 0);
    chk("t6_ddok", 32'(data_sram_data_ok), 0);
    tick();
    m_sram_data_ok = 0;
    chk("t6_err", 32'(resp_err), 1);
    tick();
    chk("t6_err_sticky", 32'(resp_err), 1);
    inst_sram_req = 1; m_sram_addr_ok = 1;
    tick();
    chk("t6_cnt1", 32'(outst_cnt), 1);
    m_sram_data_ok = 1; m_sram_rdata = 32'hdead_beef;
    #2;
    resetn = 0;
    #1;
    chk("t6r_cnt", 32'(outst_cnt), 0);
    chk("t6r_err", 32'(resp_err), 0);
    chk("t6r_mreq", 32'(m_sram_req), 0);
    chk("t6r_maddr", m_sram_addr, 0);
    chk("t6r_iaok", 32'(inst_sram_addr_ok), 0);
    chk("t6r_idok", 32'(inst_sram_data_ok), 0);
    chk("t6r_irdata", inst_sram_rdata, 0);
    chk("t6r_drdata", data_sram_rdata, 0);
    tick();
    idle_inputs();
    resetn = 1;
    tick();
    chk("t6_post_cnt", 32'(outst_cnt), 0);
    chk("t6_post_err", 32'(resp_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
